// File: rtl/aes_out_streamer.sv
// aes_out_streamer: drains the AES controller's flat result buffer as an AXI4-Stream master (1 word/cycle).
// Optional sticky error flag (err_o / err_clr) is compiled in when AES_OUT_ERR_EN is defined.
module aes_out_streamer #(
    parameter int OUT_FIFO_DEPTH = 512,
    parameter int BLK_CNT_WIDTH  = 9
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BLK_CNT_WIDTH-1:0]      blk_cnt,
    input  logic [OUT_FIFO_DEPTH*32-1:0]  out_fifo,
    output logic [31:0]                   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          busy,
`ifdef AES_OUT_ERR_EN
    input  logic                          err_clr,
    output logic                          err_o,
`endif
    output logic                          done_o
);

    localparam int TOT_W = BLK_CNT_WIDTH + 2;
    localparam int IDX_W = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
    localparam logic [TOT_W-1:0] DEPTH_W = TOT_W'(OUT_FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t             state_q;
    logic [TOT_W-1:0]   total_q;
    logic [IDX_W-1:0]   rd_idx_q;
    logic [31:0]        tdata_q;
    logic               tvalid_q;
    logic               tlast_q;
    logic               busy_q;
    logic               done_q;

    logic [TOT_W-1:0]   total_raw;
    logic [TOT_W-1:0]   total_d;
    logic               overflow;
    logic [IDX_W-1:0]   rd_idx_d;
    logic               next_is_last;
    logic [31:0]        word_arr [OUT_FIFO_DEPTH];

    always_comb begin
        for (int i = 0; i < OUT_FIFO_DEPTH; i++) begin
            word_arr[i] = out_fifo[i*32 +: 32];
        end
    end

    // Byte-free word count: four 32-bit words per 128-bit block, clamped to the buffer size.
    assign total_raw    = {blk_cnt, 2'b00};
    assign overflow     = total_raw > DEPTH_W;
    assign total_d      = overflow ? DEPTH_W : total_raw;
    assign rd_idx_d     = rd_idx_q + IDX_W'(1);
    assign next_is_last = (TOT_W'(rd_idx_d) + TOT_W'(1)) == total_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            total_q  <= '0;
            rd_idx_q <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (total_d != '0) begin
                            total_q  <= total_d;
                            rd_idx_q <= '0;
                            tdata_q  <= word_arr[0];
                            tvalid_q <= 1'b1;
                            tlast_q  <= (total_d == TOT_W'(1));
                            state_q  <= STREAM;
                        end else begin
                            total_q <= '0;
                            state_q <= DONE;
                        end
                    end
                end
                STREAM: begin
                    // Output register only advances on a handshake, so a stall holds the beat.
                    if (tvalid_q && m_axis_tready) begin
                        if (tlast_q) begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            rd_idx_q <= rd_idx_d;
                            tdata_q  <= word_arr[rd_idx_d];
                            tlast_q  <= next_is_last;
                        end
                    end
                end
                DONE: begin
                    // A zero-length transfer arrives here still busy and spends one more cycle
                    // before pulsing done; a streamed transfer arrives with done already up.
                    if (busy_q) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done_o        = done_q;

`ifdef AES_OUT_ERR_EN
    logic err_q;
    logic err_set;

    assign err_set = start && ((state_q != IDLE) || overflow);

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_set || (err_q && !err_clr);
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_aes_out_streamer.sv
// Randomized bench for aes_out_streamer: a queue-based scoreboard of expected words plus targeted timing checks.
module tb_aes_out_streamer;

    localparam int DEPTH = 512;
    localparam int BW    = 9;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [BW-1:0]         blk_cnt;
    logic [DEPTH*32-1:0]   out_fifo;
    logic [31:0]           m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic                  busy;
    logic                  done_o;
`ifdef AES_OUT_ERR_EN
    logic                  err_clr;
    logic                  err_o;
`endif

    aes_out_streamer #(
        .OUT_FIFO_DEPTH (DEPTH),
        .BLK_CNT_WIDTH  (BW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .blk_cnt       (blk_cnt),
        .out_fifo      (out_fifo),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
`ifdef AES_OUT_ERR_EN
        .err_clr       (err_clr),
        .err_o         (err_o),
`endif
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: the buffer contents and the ordered list of words the stream must carry.
    logic [31:0] mem [DEPTH];
    logic [31:0] exp_q [$];
    int          beats;
    int          dones;
    int          tlasts;
    int          rdy_mode;
    bit          mon_en;
    bit          prev_stall;
    logic [31:0] prev_dat;
    logic        prev_last;

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                check("stall_tvalid", m_axis_tvalid, 1);
                check("stall_tdata", m_axis_tdata, prev_dat);
                check("stall_tlast", m_axis_tlast, prev_last);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                beats++;
                if (m_axis_tlast) tlasts++;
                check("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("tdata", m_axis_tdata, e);
                    check("tlast", m_axis_tlast, exp_q.size() == 0);
                end
            end
            if (done_o) dones++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_dat   = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    initial begin
        int ph;
        ph = 0;
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = (ph % 3 == 0);
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            ph++;
        end
    end

    task automatic prep(input int blk, input int mode);
        int total;
        total = blk * 4;
        if (total > DEPTH) total = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            out_fifo[i*32 +: 32] = mem[i];
        end
        exp_q.delete();
        for (int i = 0; i < total; i++) exp_q.push_back(mem[i]);
        rdy_mode = mode;
        beats    = 0;
        dones    = 0;
        tlasts   = 0;
    endtask

    task automatic pulse_start(input int blk);
        @(posedge clk);
        #1;
        start   = 1'b1;
        blk_cnt = BW'(blk);
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    task automatic finish_xfer(input string tag, input int blk, input int budget);
        int n;
        int total;
        n = 0;
        total = blk * 4;
        if (total > DEPTH) total = DEPTH;
        while (dones == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        check({tag, "_done_count"}, dones, 1);
        check({tag, "_beats"}, beats, total);
        check({tag, "_tlasts"}, tlasts, (total > 0) ? 1 : 0);
        check({tag, "_left"}, exp_q.size(), 0);
        check({tag, "_idle_vld"}, m_axis_tvalid, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        blk_cnt  = '0;
        out_fifo = '0;
        rdy_mode = 0;
        mon_en   = 1'b0;
`ifdef AES_OUT_ERR_EN
        err_clr  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done_o, 0);
`ifdef AES_OUT_ERR_EN
        check("rst_err", err_o, 0);
`endif
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // One block, tready high: exact cycle-by-cycle shape.
        prep(1, 0);
        pulse_start(1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("t1_tvalid", m_axis_tvalid, (k <= 4));
            check("t1_busy", busy, (k <= 4));
            check("t1_done", done_o, (k == 5));
            check("t1_tlast", m_axis_tlast, (k == 4));
            if (k <= 4) check("t1_tdata", m_axis_tdata, mem[k-1]);
        end
        finish_xfer("t1", 1, 20);

        // Two blocks with tready 1,0,0 repeating.
        prep(2, 1);
        pulse_start(2);
        finish_xfer("t2", 2, 100);

        // Zero blocks: no beats, done two cycles after start, busy for one.
        prep(0, 0);
        pulse_start(0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("t0_tvalid", m_axis_tvalid, 0);
            check("t0_busy", busy, (k == 1));
            check("t0_done", done_o, (k == 2));
        end
        finish_xfer("t0", 0, 10);

        // Oversized count clamps to the buffer depth.
`ifdef AES_OUT_ERR_EN
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
`endif
        prep(200, 2);
        pulse_start(200);
`ifdef AES_OUT_ERR_EN
        @(negedge clk);
        check("ovf_err", err_o, 1);
`endif
        finish_xfer("ovf", 200, 4000);

        // A second start mid-stream must be ignored.
`ifdef AES_OUT_ERR_EN
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        @(negedge clk);
        check("busy_err_clear0", err_o, 0);
`endif
        prep(3, 1);
        pulse_start(3);
        repeat (3) @(posedge clk);
        #1;
        start   = 1'b1;
        blk_cnt = BW'(5);
        @(posedge clk);
        #1;
        start   = 1'b0;
        finish_xfer("dbl", 3, 200);
`ifdef AES_OUT_ERR_EN
        check("dbl_err_set", err_o, 1);
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        @(negedge clk);
        check("dbl_err_clr", err_o, 0);
`endif

        // Reset after the second beat abandons the transfer without done.
        prep(2, 0);
        pulse_start(2);
        begin
            int n;
            n = 0;
            while (beats < 2 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("rst_mid_reach", beats >= 2, 1);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_tvalid", m_axis_tvalid, 0);
        check("rst_mid_busy", busy, 0);
        exp_q.delete();
        dones = 0;
        repeat (4) @(negedge clk);
        check("rst_mid_nodone", dones, 0);
        prep(2, 0);
        pulse_start(2);
        @(negedge clk);
        check("rst_mid_restart_w0", m_axis_tdata, mem[0]);
        finish_xfer("restart", 2, 50);

        // Randomized transfers with random backpressure.
        for (int t = 0; t < 6; t++) begin
            int b;
            b = $urandom_range(0, 40);
            prep(b, 2);
            pulse_start(b);
            finish_xfer("rand", b, 1000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
